// File: rtl/tile_addr_gen.sv
// Streaming tile address generator: walks a rows x cols region and emits
// base + row*pitch + col per valid/ready handshake through a 2-stage pipeline.
module tile_addr_gen #(
    parameter int unsigned ADDR_W = 25,
    parameter int unsigned DIM_W  = 15
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              start_i,
    input  logic              abort_i,
    input  logic [ADDR_W-1:0] cfg_base_i,
    input  logic [DIM_W-1:0]  cfg_rows_i,
    input  logic [DIM_W-1:0]  cfg_cols_i,
    input  logic [DIM_W-1:0]  cfg_pitch_i,
    input  logic              cfg_col_major_i,
    output logic [ADDR_W-1:0] addr_o,
    output logic              addr_valid_o,
    input  logic              addr_ready_i,
    output logic              addr_last_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              overflow_o
);
    localparam int unsigned ProdW = 2 * DIM_W;
    localparam int unsigned SumW  = ((ADDR_W > ProdW) ? ADDR_W : ProdW) + 1;

    typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;

    state_e            state_q;
    logic [ADDR_W-1:0] base_q;
    logic [DIM_W-1:0]  rows_q, cols_q, pitch_q;
    logic              col_major_q;
    logic [DIM_W-1:0]  row_q, col_q;
    logic              s1_valid_q, s1_last_q;
    logic [ProdW-1:0]  s1_prod_q;
    logic [DIM_W-1:0]  s1_col_q;
    logic [ADDR_W-1:0] addr_q;
    logic              addr_valid_q, addr_last_q, done_q, overflow_q;

    logic              adv, row_last, col_last, last_issue;
    logic [ProdW-1:0]  prod;
    logic [SumW-1:0]   sum;

    always_comb begin
        adv        = !addr_valid_q || addr_ready_i;
        row_last   = (row_q == rows_q - DIM_W'(1));
        col_last   = (col_q == cols_q - DIM_W'(1));
        last_issue = row_last && col_last;
        prod       = ProdW'(row_q) * ProdW'(pitch_q);
        // Full-width sum so bits above ADDR_W reveal wrap-around.
        sum        = SumW'(base_q) + SumW'(s1_prod_q) + SumW'(s1_col_q);
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q      <= StIdle;
            base_q       <= '0;
            rows_q       <= '0;
            cols_q       <= '0;
            pitch_q      <= '0;
            col_major_q  <= 1'b0;
            row_q        <= '0;
            col_q        <= '0;
            s1_valid_q   <= 1'b0;
            s1_last_q    <= 1'b0;
            s1_prod_q    <= '0;
            s1_col_q     <= '0;
            addr_q       <= '0;
            addr_valid_q <= 1'b0;
            addr_last_q  <= 1'b0;
            done_q       <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (start_i) begin
                        base_q      <= cfg_base_i;
                        rows_q      <= cfg_rows_i;
                        cols_q      <= cfg_cols_i;
                        pitch_q     <= cfg_pitch_i;
                        col_major_q <= cfg_col_major_i;
                        row_q       <= '0;
                        col_q       <= '0;
                        overflow_q  <= 1'b0;
                        if (cfg_rows_i == '0 || cfg_cols_i == '0) begin
                            done_q <= 1'b1;
                        end else begin
                            state_q <= StRun;
                        end
                    end
                end
                StRun, StDrain: begin
                    if (abort_i) begin
                        state_q      <= StIdle;
                        s1_valid_q   <= 1'b0;
                        s1_last_q    <= 1'b0;
                        addr_valid_q <= 1'b0;
                        addr_last_q  <= 1'b0;
                    end else if (adv) begin
                        addr_valid_q <= s1_valid_q;
                        addr_last_q  <= s1_valid_q && s1_last_q;
                        if (s1_valid_q) begin
                            addr_q <= sum[ADDR_W-1:0];
                            if (|sum[SumW-1:ADDR_W]) overflow_q <= 1'b1;
                        end
                        if (state_q == StRun) begin
                            s1_valid_q <= 1'b1;
                            s1_last_q  <= last_issue;
                            s1_prod_q  <= prod;
                            s1_col_q   <= col_q;
                            if (last_issue) begin
                                state_q <= StDrain;
                            end else if (!col_major_q) begin
                                col_q <= col_last ? '0 : col_q + DIM_W'(1);
                                if (col_last) row_q <= row_q + DIM_W'(1);
                            end else begin
                                row_q <= row_last ? '0 : row_q + DIM_W'(1);
                                if (row_last) col_q <= col_q + DIM_W'(1);
                            end
                        end else begin
                            s1_valid_q <= 1'b0;
                            s1_last_q  <= 1'b0;
                        end
                        // Only the tagged element's handshake ends the walk.
                        if (state_q == StDrain && addr_valid_q && addr_ready_i && addr_last_q) begin
                            state_q <= StIdle;
                            done_q  <= 1'b1;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign addr_o       = addr_q;
    assign addr_valid_o = addr_valid_q;
    assign addr_last_o  = addr_last_q;
    assign busy_o       = (state_q != StIdle);
    assign done_o       = done_q;
    assign overflow_o   = overflow_q;

endmodule

// File: tb/tb_tile_addr_gen.sv
// Directed table-driven bench for tile_addr_gen; a second instance with an
// 8-bit address exercises wrap-around and the sticky overflow flag.
module tb_tile_addr_gen;
    logic        clk = 1'b0;
    logic        reset, start, abort, cfg_col_major, addr_ready;
    logic [24:0] cfg_base;
    logic [14:0] cfg_rows, cfg_cols, cfg_pitch;
    logic [24:0] addr;
    logic [7:0]  addr8;
    logic        addr_valid, addr_last, busy, done, overflow;
    logic        addr_valid8, addr_last8, busy8, done8, overflow8;

    always #5 clk = ~clk;

    tile_addr_gen u_dut (
        .clk_i(clk), .reset_i(reset), .start_i(start), .abort_i(abort),
        .cfg_base_i(cfg_base), .cfg_rows_i(cfg_rows), .cfg_cols_i(cfg_cols),
        .cfg_pitch_i(cfg_pitch), .cfg_col_major_i(cfg_col_major),
        .addr_o(addr), .addr_valid_o(addr_valid), .addr_ready_i(addr_ready),
        .addr_last_o(addr_last), .busy_o(busy), .done_o(done), .overflow_o(overflow)
    );

    tile_addr_gen #(.ADDR_W(8), .DIM_W(15)) u_dut8 (
        .clk_i(clk), .reset_i(reset), .start_i(start), .abort_i(abort),
        .cfg_base_i(cfg_base[7:0]), .cfg_rows_i(cfg_rows), .cfg_cols_i(cfg_cols),
        .cfg_pitch_i(cfg_pitch), .cfg_col_major_i(cfg_col_major),
        .addr_o(addr8), .addr_valid_o(addr_valid8), .addr_ready_i(addr_ready),
        .addr_last_o(addr_last8), .busy_o(busy8), .done_o(done8), .overflow_o(overflow8)
    );

    typedef struct {
        int          tid;
        int          cyc;
        logic        v;
        logic [24:0] a;
        logic        l;
        logic        d;
        logic        b;
        logic        o;
    } vec_t;

    vec_t vecs[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    logic        ob_v[64], ob_l[64], ob_d[64], ob_b[64], ob_o[64];
    logic        ob_v8[64], ob_l8[64], ob_d8[64], ob_b8[64], ob_o8[64];
    logic [24:0] ob_a[64];
    logic [7:0]  ob_a8[64];

    function automatic void add(int tid, int cyc, logic v, logic [24:0] a, logic l, logic d,
                                logic b, logic o);
        vecs.push_back('{tid, cyc, v, a, l, d, b, o});
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Cycle 0 is the start cycle; cfg is scrambled afterwards since it must be ignored.
    task automatic run_walk(input logic [24:0] base, input logic [14:0] rows, input logic [14:0] cols,
                            input logic [14:0] pitch, input logic cm, input logic [63:0] rmask,
                            input int abort_cyc, input int reset_cyc, input int ncyc);
        for (int c = 0; c < ncyc; c++) begin
            start         = (c == 0);
            cfg_base      = (c == 0) ? base : ~base;
            cfg_rows      = (c == 0) ? rows : 15'd7;
            cfg_cols      = (c == 0) ? cols : 15'd9;
            cfg_pitch     = (c == 0) ? pitch : 15'd3;
            cfg_col_major = (c == 0) ? cm : ~cm;
            addr_ready    = rmask[c];
            abort         = (c == abort_cyc);
            reset         = (c == reset_cyc);
            @(negedge clk);
            ob_v[c] = addr_valid;   ob_a[c] = addr;   ob_l[c] = addr_last;
            ob_d[c] = done;         ob_b[c] = busy;   ob_o[c] = overflow;
            ob_v8[c] = addr_valid8; ob_a8[c] = addr8; ob_l8[c] = addr_last8;
            ob_d8[c] = done8;       ob_b8[c] = busy8; ob_o8[c] = overflow8;
            @(posedge clk);
            #1;
        end
        start = 1'b0; abort = 1'b0; reset = 1'b0; addr_ready = 1'b1;
    endtask

    task automatic check_vecs(input int tid);
        logic        sel8, v, l, d, b, o;
        logic [24:0] a;
        int          c;
        sel8 = (tid == 4 || tid == 5 || tid == 9);
        foreach (vecs[i]) begin
            if (vecs[i].tid != tid) continue;
            c = vecs[i].cyc;
            v = sel8 ? ob_v8[c] : ob_v[c];
            a = sel8 ? {17'd0, ob_a8[c]} : ob_a[c];
            l = sel8 ? ob_l8[c] : ob_l[c];
            d = sel8 ? ob_d8[c] : ob_d[c];
            b = sel8 ? ob_b8[c] : ob_b[c];
            o = sel8 ? ob_o8[c] : ob_o[c];
            chk($sformatf("t%0d c%0d valid", tid, c), 32'(v), 32'(vecs[i].v));
            if (vecs[i].v) begin
                chk($sformatf("t%0d c%0d addr", tid, c), 32'(a), 32'(vecs[i].a));
                chk($sformatf("t%0d c%0d last", tid, c), 32'(l), 32'(vecs[i].l));
            end
            chk($sformatf("t%0d c%0d done", tid, c), 32'(d), 32'(vecs[i].d));
            chk($sformatf("t%0d c%0d busy", tid, c), 32'(b), 32'(vecs[i].b));
            chk($sformatf("t%0d c%0d ovf", tid, c), 32'(o), 32'(vecs[i].o));
        end
    endtask

    localparam logic [63:0] AllReady = 64'hFFFF_FFFF_FFFF_FFFF;

    initial begin
        // t1: 2x3 row-major, base 100, pitch 10
        add(1, 0, 0, 0, 0, 0, 0, 0);   add(1, 1, 0, 0, 0, 0, 1, 0);   add(1, 2, 0, 0, 0, 0, 1, 0);
        add(1, 3, 1, 100, 0, 0, 1, 0); add(1, 4, 1, 101, 0, 0, 1, 0); add(1, 5, 1, 102, 0, 0, 1, 0);
        add(1, 6, 1, 110, 0, 0, 1, 0); add(1, 7, 1, 111, 0, 0, 1, 0); add(1, 8, 1, 112, 1, 0, 1, 0);
        add(1, 9, 0, 0, 0, 1, 0, 0);   add(1, 10, 0, 0, 0, 0, 0, 0);
        // t2: same, column-major
        add(2, 3, 1, 100, 0, 0, 1, 0); add(2, 4, 1, 110, 0, 0, 1, 0); add(2, 5, 1, 101, 0, 0, 1, 0);
        add(2, 6, 1, 111, 0, 0, 1, 0); add(2, 7, 1, 102, 0, 0, 1, 0); add(2, 8, 1, 112, 1, 0, 1, 0);
        add(2, 9, 0, 0, 0, 1, 0, 0);
        // t3: row-major, ready low in cycles 4-6; 101 held until accepted in cycle 7
        add(3, 3, 1, 100, 0, 0, 1, 0); add(3, 4, 1, 101, 0, 0, 1, 0); add(3, 5, 1, 101, 0, 0, 1, 0);
        add(3, 6, 1, 101, 0, 0, 1, 0); add(3, 7, 1, 101, 0, 0, 1, 0); add(3, 8, 1, 102, 0, 0, 1, 0);
        add(3, 9, 1, 110, 0, 0, 1, 0); add(3, 10, 1, 111, 0, 0, 1, 0);
        add(3, 11, 1, 112, 1, 0, 1, 0); add(3, 12, 0, 0, 0, 1, 0, 0); add(3, 13, 0, 0, 0, 0, 0, 0);
        // t4: 8-bit instance, base 250, 1x8, wraps to 0 and raises overflow
        add(4, 3, 1, 250, 0, 0, 1, 0); add(4, 4, 1, 251, 0, 0, 1, 0); add(4, 7, 1, 254, 0, 0, 1, 0);
        add(4, 8, 1, 255, 0, 0, 1, 0); add(4, 9, 1, 0, 0, 0, 1, 1);   add(4, 10, 1, 1, 1, 0, 1, 1);
        add(4, 11, 0, 0, 0, 1, 0, 1);  add(4, 12, 0, 0, 0, 0, 0, 1);
        // t5: next start clears overflow
        add(5, 0, 0, 0, 0, 0, 0, 1);   add(5, 1, 0, 0, 0, 0, 1, 0);   add(5, 3, 1, 100, 1, 0, 1, 0);
        add(5, 4, 0, 0, 0, 1, 0, 0);
        // t6: empty tile
        add(6, 0, 0, 0, 0, 0, 0, 0);   add(6, 1, 0, 0, 0, 1, 0, 0);   add(6, 2, 0, 0, 0, 0, 0, 0);
        add(6, 3, 0, 0, 0, 0, 0, 0);
        // t7: 4x4 abort in cycle 5
        add(7, 3, 1, 200, 0, 0, 1, 0); add(7, 5, 1, 202, 0, 0, 1, 0); add(7, 6, 0, 0, 0, 0, 0, 0);
        add(7, 7, 0, 0, 0, 0, 0, 0);   add(7, 8, 0, 0, 0, 0, 0, 0);
        // t8: fresh walk after abort starts at base
        add(8, 3, 1, 300, 0, 0, 1, 0); add(8, 4, 1, 301, 1, 0, 1, 0); add(8, 5, 0, 0, 0, 1, 0, 0);
        // t9: 8-bit instance, reset in cycle 5 after overflow
        add(9, 3, 1, 254, 0, 0, 1, 0); add(9, 4, 1, 255, 0, 0, 1, 0); add(9, 5, 1, 0, 0, 0, 1, 1);
        add(9, 6, 0, 0, 0, 0, 0, 0);
        // t10: start right after reset, column-major 2x1
        add(10, 3, 1, 40, 0, 0, 1, 0); add(10, 4, 1, 45, 1, 0, 1, 0); add(10, 5, 0, 0, 0, 1, 0, 0);

        reset = 1'b1; start = 1'b0; abort = 1'b0; addr_ready = 1'b1;
        cfg_base = '0; cfg_rows = '0; cfg_cols = '0; cfg_pitch = '0; cfg_col_major = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset addr", 32'(addr), 0);
        chk("reset valid", 32'(addr_valid), 0);
        chk("reset last", 32'(addr_last), 0);
        chk("reset busy", 32'(busy), 0);
        chk("reset done", 32'(done), 0);
        chk("reset ovf", 32'(overflow), 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;

        run_walk(25'd100, 15'd2, 15'd3, 15'd10, 1'b0, AllReady, -1, -1, 11); check_vecs(1);
        run_walk(25'd100, 15'd2, 15'd3, 15'd10, 1'b1, AllReady, -1, -1, 11); check_vecs(2);
        run_walk(25'd100, 15'd2, 15'd3, 15'd10, 1'b0, ~64'h70, -1, -1, 14);  check_vecs(3);
        run_walk(25'd250, 15'd1, 15'd8, 15'd0, 1'b0, AllReady, -1, -1, 13);  check_vecs(4);
        run_walk(25'd100, 15'd1, 15'd1, 15'd0, 1'b0, AllReady, -1, -1, 6);   check_vecs(5);
        run_walk(25'd500, 15'd0, 15'd5, 15'd4, 1'b0, AllReady, -1, -1, 5);   check_vecs(6);
        run_walk(25'd200, 15'd4, 15'd4, 15'd16, 1'b0, AllReady, 5, -1, 9);   check_vecs(7);
        run_walk(25'd300, 15'd1, 15'd2, 15'd0, 1'b0, AllReady, -1, -1, 7);   check_vecs(8);
        run_walk(25'd254, 15'd4, 15'd4, 15'd16, 1'b0, AllReady, -1, 5, 7);   check_vecs(9);
        chk("t9 c6 addr8 reset", 32'(ob_a8[6]), 0);
        chk("t9 c6 last8 reset", 32'(ob_l8[6]), 0);
        chk("t9 c6 addr reset", 32'(ob_a[6]), 0);
        run_walk(25'd40, 15'd2, 15'd1, 15'd5, 1'b1, AllReady, -1, -1, 7);    check_vecs(10);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
